// File: rtl/uart_tx_fifo_if.sv
// Host-side write port and UART_TX hand-off signals of the transmit byte queue.
// master = system side (host writer plus UART_TX busy); slave = the queue itself.
interface uart_tx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]      wr_data;
   logic            wr_en;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] count;
   logic [7:0]      tx_data;
   logic            tx_send;
   logic            tx_busy;
   logic            overflow;

   modport master (
      output wr_data, wr_en, tx_busy,
      input  full, empty, count, tx_data, tx_send, overflow
   );

   modport slave (
      input  wr_data, wr_en, tx_busy,
      output full, empty, count, tx_data, tx_send, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding UART_TX: buffers host writes and issues one send pulse per frame.
// Optional sticky write-while-full flag: define UART_TX_FIFO_OVF_FLAG_EN.
//
// state   | meaning
// IDLE    | free to pop the head byte and pulse tx_send once UART_TX is not busy
// WAIT_HI | send issued, waiting for tx_busy to rise (bounded by BUSY_TIMEOUT)
// WAIT_LO | frame in progress, waiting for tx_busy to fall
module uart_tx_fifo #(
   parameter int ADDR_W       = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input logic           clk,
   input logic           reset,
   uart_tx_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
   localparam logic [TW-1:0]   TMO_LAST = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_send_q, tx_send_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              push, pop;

   // Full is judged on the pre-edge occupancy, so a write while full is dropped even if a pop coincides.
   assign push = bus.wr_en && !full_q;
   assign pop  = (state_q == IDLE) && !empty_q && !bus.tx_busy;

   always_comb begin
      state_d   = state_q;
      tx_send_d = 1'b0;
      tx_data_d = tx_data_q;
      tmo_d     = tmo_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               tx_data_d = mem_q[rd_ptr_q];
               tx_send_d = 1'b1;
               tmo_d     = '0;
               state_d   = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (bus.tx_busy) begin
               state_d = WAIT_LO;
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         WAIT_LO: begin
            if (!bus.tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         tx_data_q <= tx_data_d;
         tx_send_q <= tx_send_d;
         tmo_q     <= tmo_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q | (bus.wr_en & full_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign bus.overflow = overflow_q;
`else
   assign bus.overflow = 1'b0;
`endif

   assign bus.full    = full_q;
   assign bus.empty   = empty_q;
   assign bus.count   = count_q;
   assign bus.tx_data = tx_data_q;
   assign bus.tx_send = tx_send_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle, a simple
// UART_TX stand-in that holds busy for one frame per send, and literal spot checks.
module tb_uart_tx_fifo;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int BT     = 4;
   localparam int FRAME  = 80;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();
   uart_tx_fifo #(.ADDR_W(ADDR_W), .BUSY_TIMEOUT(BT)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queue plus the state of the link to UART_TX.
   // link: 0 = free, 1 = send issued and start of frame not yet seen, 2 = frame running.
   logic [7:0] mq[$];
   logic       m_send = 1'b0;
   logic [7:0] m_txd = 8'h00;
   logic       m_ovf = 1'b0;
   int         link = 0;
   int         wait_n = 0;
   bit         m_valid = 1'b0;
   bit         m_full, m_pop, m_push;
   int         pushpop_edges = 0;
   int         cyc = 0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         mq.delete();
         m_send = 1'b0;
         m_txd = 8'h00;
         m_ovf = 1'b0;
         link = 0;
         wait_n = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_full = (mq.size() == DEPTH);
         m_pop  = (link == 0) && (mq.size() != 0) && !bus.tx_busy;
         m_push = bus.wr_en && !m_full;
         if (OVF_EN && bus.wr_en && m_full) m_ovf = 1'b1;
         if (m_pop && m_push) pushpop_edges++;
         m_send = 1'b0;
         if (link == 0) begin
            if (m_pop) begin
               m_txd = mq.pop_front();
               m_send = 1'b1;
               link = 1;
               wait_n = 0;
            end
         end else if (link == 1) begin
            // give up on the frame start after BT cycles of waiting; the byte counts as sent
            if (bus.tx_busy) link = 2;
            else begin
               wait_n++;
               if (wait_n == BT) link = 0;
            end
         end else if (!bus.tx_busy) begin
            link = 0;
         end
         if (m_push) mq.push_back(bus.wr_data);
      end
   end

   int nsend = 0;
   int last_send_cyc = 0;
   int prev_send_cyc = 0;
   int peak = 0;

   always @(negedge clk) begin
      if (m_valid) begin
         check("count", bus.count, mq.size());
         check("empty", bus.empty, mq.size() == 0);
         check("full", bus.full, mq.size() == DEPTH);
         check("tx_send", bus.tx_send, m_send);
         check("tx_data", bus.tx_data, m_txd);
         check("overflow", bus.overflow, m_ovf);
         if (bus.tx_send === 1'b1) begin
            nsend++;
            prev_send_cyc = last_send_cyc;
            last_send_cyc = cyc;
         end
         if (int'(bus.count) > peak) peak = int'(bus.count);
      end
   end

   // UART_TX stand-in. bmode: 0 busy held low, 1 busy held high, 2 frame-length busy per send.
   int bmode = 0;
   int fr = 0;
   logic [7:0] rx_log[$];

   always @(negedge clk) begin
      if (reset) fr = 0;
      else if (bmode == 2) begin
         if (fr > 0) fr--;
         if (bus.tx_send === 1'b1) begin
            fr = FRAME;
            rx_log.push_back(bus.tx_data);
         end
      end
      bus.tx_busy = (bmode == 1) ? 1'b1 : ((bmode == 2) ? (fr > 0) : 1'b0);
   end

   task automatic push(input logic [7:0] b);
      bus.wr_en = 1'b1;
      bus.wr_data = b;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_rx(input int n, input string name);
      int i = 0;
      while ((rx_log.size() < n || bus.tx_busy) && i < 8000) begin
         @(negedge clk);
         i++;
      end
      check(name, (rx_log.size() == n) && !bus.tx_busy, 1);
   endtask

   logic [7:0] burst[5] = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hEE};

   initial begin
      int n0;
      int sent;
      bus.wr_en = 1'b0;
      bus.wr_data = 8'h00;

      // reset
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_count", bus.count, 0);
      check("rst_tx_send", bus.tx_send, 0);
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_overflow", bus.overflow, 0);
      reset = 1'b0;
      bmode = 2;
      repeat (2) @(negedge clk);

      // single byte latency
      push(8'hAA);
      check("single_cnt_k", bus.count, 1);
      check("single_send_k", bus.tx_send, 0);
      @(negedge clk);
      check("single_send_k1", bus.tx_send, 1);
      check("single_data_k1", bus.tx_data, 8'hAA);
      check("single_empty", bus.empty, 1);
      @(negedge clk);
      check("single_send_1clk", bus.tx_send, 0);
      wait_rx(1, "single_rx_done");
      check("single_rx", rx_log[0], 8'hAA);

      // burst ordering
      rx_log.delete();
      peak = 0;
      n0 = nsend;
      for (int i = 0; i < 5; i++) push(burst[i]);
      wait_rx(5, "burst_rx_done");
      check("burst_peak", peak, 4);
      check("burst_sends", nsend - n0, 5);
      for (int i = 0; i < 5; i++) check("burst_order", rx_log[i], burst[i]);

      // full / overflow
      rx_log.delete();
      bmode = 1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) push(8'(i));
      check("full_flag", bus.full, 1);
      check("full_count", bus.count, 16);
      push(8'h10);
      check("full_drop_count", bus.count, 16);
      check("ovf_set", bus.overflow, OVF_EN);
      bmode = 2;
      wait_rx(16, "full_rx_done");
      check("ovf_sticky", bus.overflow, OVF_EN);
      check("full_drained", bus.empty, 1);
      for (int i = 0; i < 16; i++) check("full_order", rx_log[i], 8'(i));

      // wrap with simultaneous push/pop
      rx_log.delete();
      pushpop_edges = 0;
      sent = 0;
      for (int t = 0; t < 20000 && sent < 40; t++) begin
         if (bus.count < 12 || bus.tx_send === 1'b0 && bus.count == 12 && !bus.tx_busy) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h40 + sent);
            sent++;
         end else begin
            bus.wr_en = 1'b0;
         end
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      check("wrap_all_pushed", sent, 40);
      wait_rx(40, "wrap_rx_done");
      check("wrap_pushpop_seen", pushpop_edges > 0, 1);
      for (int i = 0; i < 40; i++) check("wrap_order", rx_log[i], 8'(8'h40 + i));

      // busy timeout: two bytes, busy never rises
      bmode = 0;
      repeat (2) @(negedge clk);
      n0 = nsend;
      push(8'h55);
      push(8'h66);
      for (int i = 0; i < 50 && nsend - n0 < 2; i++) @(negedge clk);
      check("tmo_sends", nsend - n0, 2);
      check("tmo_spacing", last_send_cyc - prev_send_cyc, BT + 1);
      check("tmo_last_data", bus.tx_data, 8'h66);
      repeat (8) @(negedge clk);

      // reset while a frame is in progress
      bmode = 2;
      rx_log.delete();
      repeat (2) @(negedge clk);
      push(8'h01);
      push(8'h02);
      push(8'h03);
      for (int i = 0; i < 20 && !bus.tx_busy; i++) @(negedge clk);
      check("midrst_busy", bus.tx_busy, 1);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_count", bus.count, 0);
      check("midrst_send", bus.tx_send, 0);
      check("midrst_empty", bus.empty, 1);
      reset = 1'b0;
      n0 = nsend;
      repeat (200) @(negedge clk);
      check("midrst_no_send", nsend - n0, 0);
      check("midrst_rx", rx_log.size(), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
